// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: N-way set-associative, write-back, write-allocate data cache
// with multi-word lines, tree pseudo-LRU replacement and a word-by-word
// req/ack burst interface to backing memory. Hits complete in the access
// cycle; misses stall the core through write-back, refill and a retry cycle.
// Optional: define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module assoc_cache_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned SETS   = 256,
    parameter int unsigned WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned BOFF_W = $clog2(DATA_W / 8);
    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W - BOFF_W;
    // WORDS=1 leaves no offset bits; keep a 1-bit counter that never leaves 0
    localparam int unsigned CNT_W  = (OFF_W > 0) ? OFF_W : 1;
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Storage: data and tags are not reset, status bits are
    logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [CNT_W-1:0]  req_off;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_sel;

    logic              hit_touch;
    logic              hit_wr;
    logic              fill_wr;
    logic              fill_done;

    assign req_idx = IDX_W'(cpu_addr >> (BOFF_W + OFF_W));
    assign req_tag = TAG_W'(cpu_addr >> (ADDR_W - TAG_W));
    assign req_off = CNT_W'((cpu_addr >> BOFF_W) & ADDR_W'(WORDS - 1));

    // Build a word-aligned byte address from line fields and word counter
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                    input logic [IDX_W-1:0] i,
                                                    input logic [CNT_W-1:0] c);
        line_addr = (ADDR_W'(t) << (IDX_W + OFF_W + BOFF_W))
                  | (ADDR_W'(i) << (OFF_W + BOFF_W))
                  | (ADDR_W'(c) << BOFF_W);
    endfunction

    // Walk root-to-leaf along the accessed way, pointing each node away from it
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0]  r;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way_sh;
        logic             b;
        r      = bits;
        node   = '0;
        way_sh = way;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            b       = way_sh[WAY_W-1];
            way_sh  = way_sh << 1;
            r[node] = ~b;
            node    = node + node + WAY_W'(1) + WAY_W'(b);
        end
        return r;
    endfunction

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise follow the PLRU pointers
    always_comb begin
        logic             inv_found;
        logic [WAY_W-1:0] node;
        logic             b;
        inv_found  = 1'b0;
        victim_sel = '0;
        node       = '0;
        b          = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found  = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int unsigned l = 0; l < WAY_W; l++) begin
                b          = plru_q[req_idx][node];
                victim_sel = WAY_W'({victim_sel, b});
                node       = node + node + WAY_W'(1) + WAY_W'(b);
            end
        end
    end

    assign hit_touch = (state_q == IDLE) && cpu_req && hit;
    assign hit_wr    = hit_touch && cpu_we;
    assign fill_wr   = (state_q == FILL) && mem_ack;
    assign fill_done = fill_wr && (cnt_q == CNT_LAST);

    // Next-state and output decode for the miss-handling FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        victim_d   = victim_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        cpu_rdata  = '0;
        cpu_stall  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        cpu_rdata = data_q[req_idx][hit_way][req_off];
                    end else begin
                        cpu_stall  = 1'b1;
                        victim_d   = victim_sel;
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        cnt_d      = '0;
                        if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel])
                            state_d = WB;
                        else
                            state_d = FILL;
                    end
                end
            end
            WB: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr(tag_q[miss_idx_q][victim_q], miss_idx_q, cnt_q);
                mem_wdata = data_q[miss_idx_q][victim_q][cnt_q];
                if (mem_ack) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = line_addr(miss_tag_q, miss_idx_q, cnt_q);
                if (mem_ack) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                cpu_stall = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, burst counter and latched miss context
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            victim_q   <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            victim_q   <= victim_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
        end
    end

    // Data and tag arrays: store hits, refill words, tag on last refill word
    always_ff @(posedge clk) begin
        if (hit_wr)
            data_q[req_idx][hit_way][req_off] <= cpu_wdata;
        if (fill_wr)
            data_q[miss_idx_q][victim_q][cnt_q] <= mem_rdata;
        if (fill_done)
            tag_q[miss_idx_q][victim_q] <= miss_tag_q;
    end

    // Valid, dirty and PLRU bits; reset invalidates everything (dirty data dropped)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (hit_touch) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                if (cpu_we)
                    dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[miss_idx_q][victim_q] <= 1'b1;
                dirty_q[miss_idx_q][victim_q] <= 1'b0;
                plru_q[miss_idx_q]            <= plru_touch(plru_q[miss_idx_q], victim_q);
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit/miss event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_touch && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if ((state_q == IDLE) && cpu_req && !hit && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Scoreboard bench for assoc_cache_ctrl with default parameters. A behavioural
// cache model predicts each access's load data, stall length and the exact
// memory word traffic; monitors on the CPU and memory sides pop and compare.
module tb_assoc_cache_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 256;
    localparam int unsigned WORDS  = 4;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    assoc_cache_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .WAYS  (WAYS),
        .SETS  (SETS),
        .WORDS (WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int unsigned stall;
    } cpu_exp_t;

    int unsigned tests = 0;
    int unsigned fails = 0;

    mem_txn_t    memq[$];
    cpu_exp_t    cpuq[$];
    int unsigned wait_cyc = 0;

    // Backing memory as seen by the DUT, and the model's view of it
    logic [31:0] phys [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];

    // Behavioural cache state
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][WORDS];
    bit          m_plru  [SETS][WAYS];  // heap nodes 1..WAYS-1, 1 = victim in upper half
    int unsigned exp_hits = 0;
    int unsigned exp_miss = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    function automatic logic [31:0] phys_get(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mmem_get(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : init_word(a);
    endfunction

    function automatic int unsigned plru_victim(input int unsigned set);
        int unsigned node = 1;
        int unsigned lo   = 0;
        int unsigned size = WAYS;
        while (size > 1) begin
            size = size / 2;
            if (m_plru[set][node]) begin
                lo   = lo + size;
                node = 2 * node + 1;
            end else begin
                node = 2 * node;
            end
        end
        return lo;
    endfunction

    task automatic plru_access(input int unsigned set, input int unsigned way);
        int unsigned node = 1;
        int unsigned lo   = 0;
        int unsigned size = WAYS;
        while (size > 1) begin
            size = size / 2;
            if (way >= lo + size) begin
                m_plru[set][node] = 1'b0;
                lo   = lo + size;
                node = 2 * node + 1;
            end else begin
                m_plru[set][node] = 1'b1;
                node = 2 * node;
            end
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_plru[s][w]  = 1'b0;
            end
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic model_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                output cpu_exp_t e);
        int unsigned set, tag, off, way, ntx;
        bit          hit, found;
        logic [31:0] wa;
        set = (a >> 4) % SETS;
        tag = a >> 12;
        off = (a >> 2) % WORDS;
        hit = 1'b0;
        way = 0;
        ntx = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set][w] && m_tag[set][w] == tag) begin
                hit = 1'b1;
                way = w;
            end
        if (!hit) begin
            exp_miss++;
            found = 1'b0;
            for (int w = 0; w < WAYS; w++)
                if (!found && !m_valid[set][w]) begin
                    found = 1'b1;
                    way   = w;
                end
            if (!found) way = plru_victim(set);
            if (m_valid[set][way] && m_dirty[set][way]) begin
                for (int k = 0; k < WORDS; k++) begin
                    wa = (m_tag[set][way] << 12) | (set << 4) | (k << 2);
                    memq.push_back('{1'b1, wa, m_data[set][way][k]});
                    mmem[wa] = m_data[set][way][k];
                    ntx++;
                end
            end
            for (int k = 0; k < WORDS; k++) begin
                wa = (tag << 12) | (set << 4) | (k << 2);
                memq.push_back('{1'b0, wa, 32'h0});
                m_data[set][way][k] = mmem_get(wa);
                ntx++;
            end
            m_tag[set][way]   = tag;
            m_valid[set][way] = 1'b1;
            m_dirty[set][way] = 1'b0;
            plru_access(set, way);
        end
        exp_hits++;
        plru_access(set, way);
        e.we    = we;
        e.rdata = we ? 32'h0 : m_data[set][way][off];
        e.stall = hit ? 0 : 2 + ntx * (wait_cyc + 1);
        if (we) begin
            m_data[set][way][off] = wd;
            m_dirty[set][way]     = 1'b1;
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic wait_not_stall(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!cpu_stall) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: cpu_stall still high after 300 cycles, expected release", name);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "stall timeout");
    endtask

    task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] wd);
        cpu_exp_t e;
        model_access(a, we, wd, e);
        cpuq.push_back(e);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        wait_not_stall("access_done");
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    // Memory responder and memory-side monitor
    initial begin
        int unsigned wcnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                wcnt    = 0;
                mem_ack = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
            end else begin
                if (memq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_unexpected: got addr 0x%08h we %0d, expected no transfer", mem_addr, mem_we);
                    mem_ack = 1'b1;
                end else begin
                    check("mem_we", {31'h0, mem_we}, {31'h0, memq[0].we});
                    check("mem_addr", mem_addr, memq[0].addr);
                    if (wcnt == wait_cyc) begin
                        if (memq[0].we) check("mem_wdata", mem_wdata, memq[0].data);
                        mem_ack   = 1'b1;
                        mem_rdata = phys_get(mem_addr);
                        if (mem_we) phys[mem_addr] = mem_wdata;
                        void'(memq.pop_front());
                        wcnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                        wcnt++;
                    end
                end
            end
        end
    end

    // CPU-side monitor: measures stall length and checks completed accesses
    initial begin
        int unsigned stall_cnt = 0;
        cpu_exp_t    e;
        forever begin
            @(negedge clk);
            if (rst || !cpu_req) begin
                stall_cnt = 0;
            end else if (cpu_stall) begin
                stall_cnt++;
            end else begin
                if (cpuq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cpu_unexpected: got completion at 0x%08h, expected none", cpu_addr);
                end else begin
                    e = cpuq.pop_front();
                    if (!e.we) check("cpu_rdata", cpu_rdata, e.rdata);
                    check("stall_cycles", stall_cnt, e.stall);
                end
                stall_cnt = 0;
            end
        end
    end

    // Stimulus
    initial begin
        bit found;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cpu_stall", {31'h0, cpu_stall}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
`ifdef CACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;

        // Clean miss, hit, store hit, then dirty eviction in set 0x10
        do_access(32'h0000_0100, 1'b0, 32'h0);
        do_access(32'h0000_0108, 1'b0, 32'h0);
        do_access(32'h0000_0104, 1'b1, 32'hDEADBEEF);
        do_access(32'h0000_0104, 1'b0, 32'h0);
        do_access(32'h0000_1100, 1'b0, 32'h0);
        do_access(32'h0000_2100, 1'b0, 32'h0);
        do_access(32'h0000_3100, 1'b0, 32'h0);
        do_access(32'h0000_4100, 1'b0, 32'h0);
        do_access(32'h0000_0104, 1'b0, 32'h0);

        // PLRU replacement order in set 0
        do_access(32'h0000_0000, 1'b0, 32'h0);
        do_access(32'h0000_1000, 1'b0, 32'h0);
        do_access(32'h0000_2000, 1'b0, 32'h0);
        do_access(32'h0000_3000, 1'b0, 32'h0);
        do_access(32'h0000_0000, 1'b0, 32'h0);
        do_access(32'h0000_4000, 1'b0, 32'h0);
        do_access(32'h0000_0000, 1'b0, 32'h0);
        do_access(32'h0000_2000, 1'b0, 32'h0);

        // Reset on the second refill word of a miss to 0x200
        for (int k = 0; k < WORDS; k++)
            memq.push_back('{1'b0, 32'h200 + 32'(k * 4), 32'h0});
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0200;
        found    = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 32'h204) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL abort_wait: got no fill of 0x204, expected one within 50 cycles");
        end
        #1;
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        memq.delete();
        model_reset();
        @(negedge clk);
        check("abort_mem_req", {31'h0, mem_req}, 32'h0);
        check("abort_cpu_stall", {31'h0, cpu_stall}, 32'h0);
`ifdef CACHE_STATS_EN
        check("abort_hit_cnt", hit_cnt, 32'h0);
        check("abort_miss_cnt", miss_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;
        do_access(32'h0000_0200, 1'b0, 32'h0);
        do_access(32'h0000_0104, 1'b0, 32'h0);

        // Slow memory: three idle cycles before every ack
        wait_cyc = 3;
        do_access(32'h0000_5300, 1'b0, 32'h0);
        wait_cyc = 0;

        // Randomised traffic over two sets and eight tags
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            wait_cyc = $urandom_range(0, 1);
            a = ($urandom_range(0, 7) << 12) | (($urandom_range(0, 1) + 5) << 4)
              | ($urandom_range(0, 3) << 2);
            do_access(a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end

        @(negedge clk);
        check("cpuq_drained", cpuq.size(), 32'h0);
        check("memq_drained", memq.size(), 32'h0);
`ifdef CACHE_STATS_EN
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_miss);
`endif
        finish_tb();
    end

endmodule
